// File: rtl/reg_scoreboard_pkg.sv
// reg_scoreboard_pkg
//   Shared core definitions for the register scoreboard and the hazard /
//   forwarding logic that consumes it: default register count, default
//   result-latency width, register index and latency types.
package reg_scoreboard_pkg;

  localparam int unsigned SB_NUM_REGS = 16;
  localparam int unsigned SB_LAT_W    = 2;
  localparam int unsigned REG_IDX_W   = 4;

  typedef logic [REG_IDX_W-1:0] reg_idx_t;
  typedef logic [SB_LAT_W-1:0]  lat_t;

endpackage

// File: rtl/reg_scoreboard_sb_entry.sv
// sb_entry
//   Tracking state for one architectural register: a busy bit and a
//   result-latency countdown.
//   Priority at each rising edge: reset > load (new issue) > clear/decrement.
//   Ports:
//     clk, rst  : clock, synchronous active-high reset
//     load      : accepted issue writes this register; take lat
//     lat       : latency value loaded on load
//     clr       : writeback to this register completes this cycle
//     busy      : a write is in flight
//     pending   : busy and result not yet on the bypass network
//     bypass    : busy and result available on the bypass network
module sb_entry
  import reg_scoreboard_pkg::*;
#(
  parameter int unsigned LAT_W = SB_LAT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [LAT_W-1:0] lat,
  input  logic             clr,
  output logic             busy,
  output logic             pending,
  output logic             bypass
);

  logic [LAT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= 1'b0;
      cnt  <= '0;
    end else if (load) begin
      busy <= 1'b1;
      cnt  <= lat;
    end else begin
      if (clr) begin
        busy <= 1'b0;
      end
      // countdown saturates at zero and keeps running independent of busy
      if (cnt != '0) begin
        cnt <= cnt - LAT_W'(1);
      end
    end
  end

  always_comb begin
    pending = busy & (cnt != '0);
    bypass  = busy & (cnt == '0);
  end

endmodule

// File: rtl/reg_scoreboard.sv
// reg_scoreboard
//   Issue-stage register scoreboard. Tracks in-flight writes per register,
//   stalls on RAW (result not yet bypassable) and WAW hazards, and flags
//   operands that must be taken from the bypass network.
//   Register 0 is hard-zero: never busy, never stalls, never forwarded.
//   Ports:
//     clk, rst      : clock, synchronous active-high reset
//     issue_valid   : instruction presented this cycle
//     issue_rs/rt   : source register indices
//     issue_rd      : destination register index
//     issue_wr      : instruction writes issue_rd
//     issue_lat     : cycles until the result reaches the bypass network
//     wb_valid      : writeback completes this cycle
//     wb_rd         : writeback destination index
//     stall         : presented instruction refused (combinational)
//     fwd_rs/fwd_rt : operand from bypass network (combinational)
//     busy_mask     : registered busy bits
module reg_scoreboard
  import reg_scoreboard_pkg::*;
#(
  parameter int unsigned NUM_REGS = SB_NUM_REGS,
  parameter int unsigned LAT_W    = SB_LAT_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                issue_valid,
  input  reg_idx_t            issue_rs,
  input  reg_idx_t            issue_rt,
  input  reg_idx_t            issue_rd,
  input  logic                issue_wr,
  input  logic [LAT_W-1:0]    issue_lat,
  input  logic                wb_valid,
  input  reg_idx_t            wb_rd,
  output logic                stall,
  output logic                fwd_rs,
  output logic                fwd_rt,
  output logic [NUM_REGS-1:0] busy_mask
);

  logic [NUM_REGS-1:0] busy;
  logic [NUM_REGS-1:0] pend;
  logic [NUM_REGS-1:0] byp;
  logic [NUM_REGS-1:0] rs_hit;
  logic [NUM_REGS-1:0] rt_hit;
  logic [NUM_REGS-1:0] rd_hit;
  logic [NUM_REGS-1:0] wb_hit;
  logic [NUM_REGS-1:0] load;
  logic                accept;
  logic                rs_pend;
  logic                rt_pend;
  logic                rd_busy;
  logic                wb_frees_rd;

  // Index decode is done as one-hot compares per entry so that any
  // NUM_REGS works without out-of-range array indexing.
  for (genvar i = 0; i < NUM_REGS; i++) begin : g_entry
    localparam reg_idx_t IDX = reg_idx_t'(i);

    assign rs_hit[i] = (issue_rs == IDX);
    assign rt_hit[i] = (issue_rt == IDX);
    assign rd_hit[i] = (issue_rd == IDX);
    assign wb_hit[i] = wb_valid & (wb_rd == IDX);
    assign load[i]   = (i != 0) & accept & issue_wr & rd_hit[i];

    sb_entry #(
      .LAT_W (LAT_W)
    ) u_entry (
      .clk     (clk),
      .rst     (rst),
      .load    (load[i]),
      .lat     (issue_lat),
      .clr     (wb_hit[i]),
      .busy    (busy[i]),
      .pending (pend[i]),
      .bypass  (byp[i])
    );
  end

  always_comb begin
    rs_pend     = |(rs_hit & pend);
    rt_pend     = |(rt_hit & pend);
    rd_busy     = |(rd_hit & busy);
    // a writeback retiring rd this same cycle resolves the WAW hazard
    wb_frees_rd = wb_valid & (wb_rd == issue_rd);

    stall  = issue_valid & (rs_pend | rt_pend | (issue_wr & rd_busy & ~wb_frees_rd));
    accept = issue_valid & ~stall;

    fwd_rs = issue_valid & (issue_rs != '0) & |(rs_hit & (byp | (wb_hit & busy)));
    fwd_rt = issue_valid & (issue_rt != '0) & |(rt_hit & (byp | (wb_hit & busy)));

    busy_mask = busy;
  end

endmodule
